ctrl_pipe_chain: RTL and testbench

//  Parametrised control-signal pipeline register chain. It is the next generation of the fixed 4-bit EX/MEM control latch.
//  - Carries a WIDTH-bit control bundle plus a valid bit through DEPTH register stages.
//  - Per-stage stall: hold the stage and everything upstream.
//  - Per-stage flush: kill the stage's contents.
//  - Automatic bubble insertion between a held stage and an advancing stage.
//  - Saturating stall/flush performance counters.
//  - Replaces the per-boundary control latches (ID/EX, EX/MEM, MEM/WB) with one block.

---
 rtl/ctrl_pipe_chain_pkg.sv | 15 +
 rtl/ctrl_pipe_chain_if.sv | 28 ++
 rtl/ctrl_pipe_chain_slot.sv | 52 +++++
 rtl/ctrl_pipe_chain.sv | 90 +++++++++
 tb/tb_ctrl_pipe_chain.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pipe_chain_pkg.sv
// Shared constants for the control-signal pipeline chain: the classic
// EX/MEM control-bit layout and the default bubble pattern.
package ctrl_pipe_pkg;

    localparam int CTL_W        = 4;

    localparam int CTL_MEMREAD  = 0;
    localparam int CTL_MEMTOREG = 1;
    localparam int CTL_MEMWRITE = 2;
    localparam int CTL_REGWRITE = 3;

    // All-zero control word: no memory access, no register write.
    localparam logic [CTL_W-1:0] CTL_BUBBLE = 4'b0000;

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// Bundle of the pipeline's data, stall/flush controls and status outputs.
// The DUT connects through the slave modport; the driver uses master.
interface ctrl_pipe_chain_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in_ctrl;
    logic             in_valid;
    logic [DEPTH-1:0] stall;
    logic [DEPTH-1:0] flush;
    logic             cnt_clr;
    logic [WIDTH-1:0] out_ctrl;
    logic             out_valid;
    logic [DEPTH-1:0] stage_vld;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output in_ctrl, in_valid, stall, flush, cnt_clr,
        input  out_ctrl, out_valid, stage_vld, stall_cnt, flush_cnt
    );

    modport slave (
        input  in_ctrl, in_valid, stall, flush, cnt_clr,
        output out_ctrl, out_valid, stage_vld, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_pipe_chain_slot.sv
// One pipeline stage: a control word plus its valid bit. Priority is
// kill > hold > insert_bubble > load. An invalid stage always carries BUBBLE.
module ctrl_pipe_slot #(
    parameter int               WIDTH  = 4,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] src_ctrl,
    input  logic             src_vld,
    input  logic             hold,
    input  logic             kill,
    input  logic             insert_bubble,
    output logic [WIDTH-1:0] slot_ctrl,
    output logic             slot_vld
);
    logic [WIDTH-1:0] ctrl_q, ctrl_d;
    logic             vld_q, vld_d;

    // Next-state selection for this stage.
    always_comb begin
        ctrl_d = ctrl_q;
        vld_d  = vld_q;
        if (kill) begin
            vld_d  = 1'b0;
            ctrl_d = BUBBLE;
        end else if (hold) begin
            ctrl_d = ctrl_q;
            vld_d  = vld_q;
        end else if (insert_bubble) begin
            vld_d  = 1'b0;
            ctrl_d = BUBBLE;
        end else begin
            vld_d  = src_vld;
            ctrl_d = src_vld ? src_ctrl : BUBBLE;
        end
    end

    // Stage register with synchronous reset to an empty bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            ctrl_q <= BUBBLE;
        end else begin
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign slot_ctrl = ctrl_q;
    assign slot_vld  = vld_q;
endmodule

// File: rtl/ctrl_pipe_chain.sv
// Parametrised chain of control-latch stages with per-stage stall/flush,
// automatic bubble insertion and saturating stall/flush event counters.
module ctrl_pipe_chain
    import ctrl_pipe_pkg::*;
#(
    parameter int               WIDTH  = CTL_W,
    parameter int               DEPTH  = 1,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(CTL_BUBBLE),
    parameter int               CNT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    ctrl_pipe_chain_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DEPTH-1:0] hold_s;
    logic [WIDTH-1:0] stg_ctrl_s [DEPTH];
    logic [DEPTH-1:0] stg_vld_s;
    logic             flush_hit_s;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // A stage is held when it or any stage downstream of it stalls.
    always_comb begin
        hold_s = {DEPTH{1'b0}};
        hold_s[DEPTH-1] = bus.stall[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            hold_s[k] = hold_s[k+1] | bus.stall[k];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            ctrl_pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_slot (
                .clk(clk), .rst(rst),
                .src_ctrl(bus.in_ctrl), .src_vld(bus.in_valid),
                .hold(hold_s[k]), .kill(bus.flush[k]), .insert_bubble(1'b0),
                .slot_ctrl(stg_ctrl_s[k]), .slot_vld(stg_vld_s[k])
            );
        end else begin : g_body
            ctrl_pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_slot (
                .clk(clk), .rst(rst),
                .src_ctrl(stg_ctrl_s[k-1]), .src_vld(stg_vld_s[k-1]),
                .hold(hold_s[k]), .kill(bus.flush[k]), .insert_bubble(hold_s[k-1]),
                .slot_ctrl(stg_ctrl_s[k]), .slot_vld(stg_vld_s[k])
            );
        end
    end

    assign flush_hit_s = |(bus.flush & stg_vld_s);

    // Saturating counters; a clear wins over a same-cycle increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.cnt_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
            flush_cnt_d = {CNT_W{1'b0}};
        end else begin
            if ((|bus.stall) && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (flush_hit_s && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.out_ctrl  = stg_ctrl_s[DEPTH-1];
    assign bus.out_valid = stg_vld_s[DEPTH-1];
    assign bus.stage_vld = stg_vld_s;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Bench for ctrl_pipe_chain: two DEPTH=3 instances share stimulus, one with a
// wide counter and non-zero bubble, one with a 2-bit counter and default bubble.
module tb_ctrl_pipe_chain;
    localparam logic [3:0] BUB_A = 4'hE;
    localparam logic [3:0] BUB_B = 4'h0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ctrl_pipe_chain_if #(.WIDTH(4), .DEPTH(3), .CNT_W(16)) ifa ();
    ctrl_pipe_chain_if #(.WIDTH(4), .DEPTH(3), .CNT_W(2))  ifb ();

    ctrl_pipe_chain #(.WIDTH(4), .DEPTH(3), .BUBBLE(BUB_A), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    ctrl_pipe_chain #(.WIDTH(4), .DEPTH(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;

    // Reference: list of stage contents (valid + word) and event counts.
    logic [3:0]  mc [3];
    logic        mv [3];
    int unsigned m_sc_a, m_fc_a, m_sc_b, m_fc_b;
    bit          ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic v, input logic [2:0] st,
                         input logic [2:0] fl, input logic clr);
        ifa.in_ctrl = c;  ifa.in_valid = v;  ifa.stall = st;  ifa.flush = fl;  ifa.cnt_clr = clr;
        ifb.in_ctrl = c;  ifb.in_valid = v;  ifb.stall = st;  ifb.flush = fl;  ifb.cnt_clr = clr;
    endtask

    function automatic bit frozen(input int k, input logic [2:0] st);
        return (st >> k) != 3'b000;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic model_update();
        logic [3:0] nc [3];
        logic       nv [3];
        bit         hit;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin mv[k] = 1'b0; mc[k] = 4'h0; end
            m_sc_a = 0; m_fc_a = 0; m_sc_b = 0; m_fc_b = 0;
            ready = 1'b1;
            return;
        end
        hit = 1'b0;
        for (int k = 0; k < 3; k++) if (ifa.flush[k] && mv[k]) hit = 1'b1;
        if (ifa.cnt_clr) begin
            m_sc_a = 0; m_fc_a = 0; m_sc_b = 0; m_fc_b = 0;
        end else begin
            if (ifa.stall != 3'b000) begin
                m_sc_a = sat_inc(m_sc_a, 65535); m_sc_b = sat_inc(m_sc_b, 3);
            end
            if (hit) begin
                m_fc_a = sat_inc(m_fc_a, 65535); m_fc_b = sat_inc(m_fc_b, 3);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (ifa.flush[k])                     begin nv[k] = 1'b0; nc[k] = 4'h0; end
            else if (frozen(k, ifa.stall))        begin nv[k] = mv[k]; nc[k] = mc[k]; end
            else if (k > 0 && frozen(k - 1, ifa.stall)) begin nv[k] = 1'b0; nc[k] = 4'h0; end
            else if (k == 0)                      begin nv[k] = ifa.in_valid; nc[k] = ifa.in_ctrl; end
            else                                  begin nv[k] = mv[k-1]; nc[k] = mc[k-1]; end
        end
        for (int k = 0; k < 3; k++) begin mv[k] = nv[k]; mc[k] = nc[k]; end
    endtask

    task automatic compare_all();
        logic [3:0] ea, eb;
        if (!ready) return;
        ea = mv[2] ? mc[2] : BUB_A;
        eb = mv[2] ? mc[2] : BUB_B;
        chk("a_out_ctrl",  ifa.out_ctrl,  ea);
        chk("a_out_valid", ifa.out_valid, mv[2]);
        chk("a_stage_vld", ifa.stage_vld, {mv[2], mv[1], mv[0]});
        chk("a_stall_cnt", ifa.stall_cnt, m_sc_a);
        chk("a_flush_cnt", ifa.flush_cnt, m_fc_a);
        chk("b_out_ctrl",  ifb.out_ctrl,  eb);
        chk("b_out_valid", ifb.out_valid, mv[2]);
        chk("b_stage_vld", ifb.stage_vld, {mv[2], mv[1], mv[0]});
        chk("b_stall_cnt", ifb.stall_cnt, m_sc_b);
        chk("b_flush_cnt", ifb.flush_cnt, m_fc_b);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pin_out(input string name, input logic [3:0] c, input logic v);
        chk({name, "_ctrl"},  ifa.out_ctrl,  c);
        chk({name, "_valid"}, ifa.out_valid, v);
    endtask

    initial begin
        // Reset with every input high.
        rst = 1'b1;
        drive(4'hF, 1'b1, 3'b111, 3'b111, 1'b1);
        step(); step();
        pin_out("rst", BUB_A, 1'b0);
        chk("rst_stage_vld", ifa.stage_vld, 3'b000);
        chk("rst_stall_cnt", ifa.stall_cnt, 16'd0);
        chk("rst_flush_cnt", ifa.flush_cnt, 16'd0);
        chk("rst_b_ctrl",    ifb.out_ctrl,  4'h0);

        // Plain stream: latency of three edges.
        rst = 1'b0;
        drive(4'h1, 1'b1, 3'b000, 3'b000, 1'b0); step();
        drive(4'h2, 1'b1, 3'b000, 3'b000, 1'b0); step();
        drive(4'h3, 1'b1, 3'b000, 3'b000, 1'b0); step();
        pin_out("lat1", 4'h1, 1'b1);
        drive(4'h0, 1'b0, 3'b000, 3'b000, 1'b0); step();
        pin_out("lat2", 4'h2, 1'b1);
        step();
        pin_out("lat3", 4'h3, 1'b1);
        step();
        pin_out("drain", BUB_A, 1'b0);

        // Stall stage 1 for two cycles with 4,5,6 in flight and 7 waiting.
        drive(4'h4, 1'b1, 3'b000, 3'b000, 1'b0); step();
        drive(4'h5, 1'b1, 3'b000, 3'b000, 1'b0); step();
        drive(4'h6, 1'b1, 3'b000, 3'b000, 1'b0); step();
        pin_out("pre_stall", 4'h4, 1'b1);
        drive(4'h7, 1'b1, 3'b010, 3'b000, 1'b0); step();
        pin_out("stall_bub1", BUB_A, 1'b0);
        step();
        pin_out("stall_bub2", BUB_A, 1'b0);
        chk("stall_stage_vld", ifa.stage_vld, 3'b011);
        chk("stall_cnt2", ifa.stall_cnt, 16'd2);
        drive(4'h7, 1'b1, 3'b000, 3'b000, 1'b0); step();
        pin_out("resume5", 4'h5, 1'b1);
        drive(4'h0, 1'b0, 3'b000, 3'b000, 1'b0); step();
        pin_out("resume6", 4'h6, 1'b1);
        step();
        pin_out("resume7", 4'h7, 1'b1);
        step();

        // Flush beats stall on stage 2 holding 4'hA.
        drive(4'hA, 1'b1, 3'b000, 3'b000, 1'b0); step();
        drive(4'h0, 1'b0, 3'b000, 3'b000, 1'b0); step(); step();
        pin_out("pre_flush", 4'hA, 1'b1);
        drive(4'h0, 1'b0, 3'b100, 3'b100, 1'b0); step();
        pin_out("flushed", BUB_A, 1'b0);
        chk("flush_cnt1", ifa.flush_cnt, 16'd1);

        // Counter clear, saturation of the 2-bit counter, clear beating increment.
        drive(4'h0, 1'b0, 3'b000, 3'b000, 1'b1); step();
        chk("clr_b_stall", ifb.stall_cnt, 2'd0);
        chk("clr_a_flush", ifa.flush_cnt, 16'd0);
        drive(4'h0, 1'b0, 3'b001, 3'b000, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk("sat_b_stall", ifb.stall_cnt, 2'd3);
        chk("sat_a_stall", ifa.stall_cnt, 16'd5);
        drive(4'h0, 1'b0, 3'b001, 3'b000, 1'b1); step();
        chk("clr_win_b", ifb.stall_cnt, 2'd0);
        chk("clr_win_a", ifa.stall_cnt, 16'd0);

        // Reset mid-stream while stage 0 is stalled, then refill.
        drive(4'h9, 1'b1, 3'b000, 3'b000, 1'b0); step();
        drive(4'hB, 1'b1, 3'b000, 3'b000, 1'b0); step();
        rst = 1'b1;
        drive(4'hC, 1'b1, 3'b001, 3'b000, 1'b0); step();
        chk("mid_rst_vld", ifa.stage_vld, 3'b000);
        pin_out("mid_rst", BUB_A, 1'b0);
        rst = 1'b0;
        drive(4'h1, 1'b1, 3'b000, 3'b000, 1'b0); step();
        drive(4'h2, 1'b1, 3'b000, 3'b000, 1'b0); step();
        drive(4'h3, 1'b1, 3'b000, 3'b000, 1'b0); step();
        pin_out("refill", 4'h1, 1'b1);

        // Mixed traffic checked cycle by cycle against the reference.
        for (int i = 0; i < 80; i++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                  ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                  1'($urandom_range(0, 19) == 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
